mlp_train_seq: RTL and testbench

Training/evaluation sequencer that sits on the input side of the O/X MLP classifier. It holds a small labelled set of 4x4 patterns and drives the classifier's x / is_O / learn inputs. It reads back the classifier's binary decision y, counts misclassifications per epoch, and asserts learn only on mismatches. It repeats epochs until one epoch has zero errors or an epoch limit is reached, then reports done, converged and the counts.

---
 rtl/mlp_ox_pkg.sv | 33 +++
 rtl/mlp_sample_ram.sv | 38 +++
 rtl/mlp_train_seq.sv | 214 +++++++++++++++++++++
 tb/tb_mlp_train_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_ox_pkg.sv
// Shared types and constants for the O/X MLP training sequencer.
package mlp_ox_pkg;

    // Width of one flattened 4x4 pattern, bit r*4+c
    localparam int PAT_W = 16;

    // Reference glyphs: an "O" ring and its "X" complement
    localparam logic [PAT_W-1:0] PAT_O = 16'h6996;
    localparam logic [PAT_W-1:0] PAT_X = 16'h9669;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EVAL      = 3'd1,
        ST_LEARN     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_NEXT      = 3'd4,
        ST_EPOCH_END = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // One labelled training sample; lbl = 1 means the pattern is an O
    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic             lbl;
    } sample_t;

    // True in the two states where the sample store may be rewritten
    function automatic logic is_rest_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/mlp_sample_ram.sv
// Small register file of labelled samples: one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module mlp_sample_ram
    import mlp_ox_pkg::*;
#(
    parameter int NUM_SAMPLES = 8,
    parameter int AW          = 3
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  sample_t       wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output sample_t       rd_data_o
);

    // Depth in an AW+1 bit form so the range test never degenerates
    localparam logic [AW:0] DEPTH = (AW + 1)'(NUM_SAMPLES);

    sample_t mem_q [NUM_SAMPLES];

    logic wr_hit;
    logic rd_hit;

    // Addresses beyond the populated depth are neither written nor read
    assign wr_hit = wr_en_i && ({1'b0, wr_addr_i} < DEPTH);
    assign rd_hit = ({1'b0, rd_addr_i} < DEPTH);

    // Store the incoming sample when the write lands inside the table
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = rd_hit ? mem_q[rd_addr_i] : '0;

endmodule

// File: rtl/mlp_train_seq.sv
// Training / evaluation sequencer for the O/X MLP classifier. Presents each
// stored sample, waits out the classifier latency, compares the decision
// with the label, pulses learn on mismatches and repeats whole epochs until
// an error-free epoch or the epoch limit.
module mlp_train_seq
    import mlp_ox_pkg::*;
#(
    parameter int NUM_SAMPLES = 8,
    parameter int AW          = 3,
    parameter int LAT         = 3,
    parameter int MAX_EPOCH   = 15,
    parameter int EW          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             samp_we,
    input  logic [AW-1:0]    samp_addr,
    input  logic [PAT_W-1:0] samp_pat,
    input  logic             samp_lbl,
    output logic [PAT_W-1:0] x,
    output logic             is_O,
    output logic             learn,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic [EW-1:0]    epoch_cnt,
    output logic [AW:0]      err_cnt,
    output logic [AW:0]      last_err_cnt
);

    // Wait counter must reach LAT in EVAL and LAT-1 in SETTLE
    localparam int            CW         = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CW-1:0] EVAL_END   = CW'(LAT);
    localparam logic [CW-1:0] SETTLE_END = CW'(LAT - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_SAMPLES - 1);
    localparam logic [EW-1:0] EPOCH_LIM  = EW'(MAX_EPOCH);

    state_e           state_q;
    logic [AW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    logic [PAT_W-1:0] x_q;
    logic             is_o_q;
    logic             learn_q;
    logic             busy_q;
    logic             done_q;
    logic             conv_q;
    logic [EW-1:0]    epoch_q;
    logic [AW:0]      err_q;
    logic [AW:0]      last_err_q;

    logic [EW-1:0]    epoch_d;
    logic [AW-1:0]    rd_addr_d;
    logic             ram_we;
    sample_t          wr_sample;
    sample_t          rd_sample;

    // ------------------------------------------------------------------
    // Sample store
    // ------------------------------------------------------------------
    assign ram_we    = samp_we && is_rest_state(state_q);
    assign wr_sample = '{pat: samp_pat, lbl: samp_lbl};

    // x is loaded on every entry into EVAL: from NEXT the following
    // sample is wanted, from every other entry point it is sample 0.
    assign rd_addr_d = (state_q == ST_NEXT) ? (idx_q + AW'(1)) : '0;

    mlp_sample_ram #(
        .NUM_SAMPLES (NUM_SAMPLES),
        .AW          (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (samp_addr),
        .wr_data_i (wr_sample),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (rd_sample)
    );

    // Saturating epoch increment used at the end of each epoch
    assign epoch_d = (&epoch_q) ? epoch_q : (epoch_q + EW'(1));

    // ------------------------------------------------------------------
    // Sequencer FSM with all outputs registered
    // ------------------------------------------------------------------
    // Single state machine: walks samples, counts errors, manages epochs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            is_o_q     <= 1'b0;
            learn_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            epoch_q    <= '0;
            err_q      <= '0;
            last_err_q <= '0;
        end else if (abort) begin
            // Counters are left alone so a debugger can see where it stopped
            state_q <= ST_IDLE;
            learn_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    learn_q <= 1'b0;
                    if (start) begin
                        epoch_q <= '0;
                        err_q   <= '0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        conv_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        x_q     <= rd_sample.pat;
                        is_o_q  <= rd_sample.lbl;
                        state_q <= ST_EVAL;
                    end
                end

                ST_EVAL: begin
                    // x has been stable since cnt 0, so y_in is valid at LAT
                    if (cnt_q == EVAL_END) begin
                        cnt_q <= '0;
                        if (y_in != is_o_q) begin
                            err_q   <= err_q + (AW + 1)'(1);
                            learn_q <= 1'b1;
                            state_q <= ST_LEARN;
                        end else begin
                            state_q <= ST_NEXT;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_LEARN: begin
                    // Single-cycle update strobe; x stays on the same sample
                    learn_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    // Let the weight update drain through the classifier
                    if (cnt_q == SETTLE_END) begin
                        cnt_q   <= '0;
                        state_q <= ST_NEXT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_EPOCH_END;
                    end else begin
                        idx_q   <= idx_q + AW'(1);
                        cnt_q   <= '0;
                        x_q     <= rd_sample.pat;
                        is_o_q  <= rd_sample.lbl;
                        state_q <= ST_EVAL;
                    end
                end

                ST_EPOCH_END: begin
                    last_err_q <= err_q;
                    epoch_q    <= epoch_d;
                    if (err_q == '0) begin
                        conv_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (epoch_d == EPOCH_LIM) begin
                        conv_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        err_q   <= '0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        x_q     <= rd_sample.pat;
                        is_o_q  <= rd_sample.lbl;
                        state_q <= ST_EVAL;
                    end
                end

                default: begin
                    learn_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x            = x_q;
    assign is_O         = is_o_q;
    assign learn        = learn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign converged    = conv_q;
    assign epoch_cnt    = epoch_q;
    assign err_cnt      = err_q;
    assign last_err_cnt = last_err_q;

endmodule

// File: tb/tb_mlp_train_seq.sv
// Self-checking bench for mlp_train_seq: a transaction-level model expands
// each run into an expected per-cycle output trace that is compared on
// every falling edge, plus literal cycle/pulse counts for each scenario.
module tb_mlp_train_seq;
    import mlp_ox_pkg::*;

    localparam int NUM  = 8;
    localparam int AW   = 3;
    localparam int LAT  = 3;
    localparam int MAXE = 3;
    localparam int EW   = 8;

    typedef struct packed {
        logic [15:0]   x;
        logic          is_o;
        logic          learn;
        logic          busy;
        logic          done;
        logic          conv;
        logic [EW-1:0] epoch;
        logic [AW:0]   err;
        logic [AW:0]   last_err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          samp_we;
    logic [AW-1:0] samp_addr;
    logic [15:0]   samp_pat;
    logic          samp_lbl;
    logic [15:0]   x;
    logic          is_O;
    logic          learn;
    logic          y_in;
    logic          busy;
    logic          done;
    logic          converged;
    logic [EW-1:0] epoch_cnt;
    logic [AW:0]   err_cnt;
    logic [AW:0]   last_err_cnt;

    mlp_train_seq #(
        .NUM_SAMPLES (NUM),
        .AW          (AW),
        .LAT         (LAT),
        .MAX_EPOCH   (MAXE),
        .EW          (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .samp_we      (samp_we),
        .samp_addr    (samp_addr),
        .samp_pat     (samp_pat),
        .samp_lbl     (samp_lbl),
        .x            (x),
        .is_O         (is_O),
        .learn        (learn),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .epoch_cnt    (epoch_cnt),
        .err_cnt      (err_cnt),
        .last_err_cnt (last_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- classifier stub ----------------
    // mode 0: always right, mode 1: always says O, mode 2: wrong until first learn
    int stub_mode   = 0;
    int learn_total = 0;
    int learn_base  = 0;
    int busy_total  = 0;

    always @(posedge clk) if (learn) learn_total <= learn_total + 1;

    always_comb begin
        y_in = is_O;
        case (stub_mode)
            0:       y_in = is_O;
            1:       y_in = 1'b1;
            default: y_in = (learn_total != learn_base) ? is_O : ~is_O;
        endcase
    end

    // ---------------- model state ----------------
    logic [15:0] m_pat [NUM];
    logic        m_lbl [NUM];
    int          m_last_err = 0;
    exp_t        q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at t=%0t", name, act, req, $time);
    endtask

    function automatic exp_t dut_vec();
        return {x, is_O, learn, busy, done, converged, epoch_cnt, err_cnt, last_err_cnt};
    endfunction

    // Expand one run into the expected per-cycle trace; returns busy cycles
    task automatic build(input int mode, output int nbusy);
        exp_t e;
        int   err;
        int   ep;
        bit   lrn;
        bit   y;
        lrn   = 0;
        ep    = 0;
        nbusy = 0;
        e     = '0;
        e.busy     = 1'b1;
        e.last_err = (AW + 1)'(m_last_err);
        forever begin
            err     = 0;
            e.err   = '0;
            e.epoch = EW'(ep);
            for (int s = 0; s < NUM; s++) begin
                e.x    = m_pat[s];
                e.is_o = m_lbl[s];
                repeat (LAT + 1) begin q.push_back(e); nbusy++; end
                if (mode == 0)      y = m_lbl[s];
                else if (mode == 1) y = 1'b1;
                else                y = lrn ? m_lbl[s] : ~m_lbl[s];
                if (y != m_lbl[s]) begin
                    err++;
                    lrn     = 1;
                    e.err   = (AW + 1)'(err);
                    e.learn = 1'b1;
                    q.push_back(e); nbusy++;
                    e.learn = 1'b0;
                    repeat (LAT) begin q.push_back(e); nbusy++; end
                end
                q.push_back(e); nbusy++;          // advance cycle
            end
            q.push_back(e); nbusy++;              // epoch close cycle
            ep++;
            m_last_err = err;
            e.last_err = (AW + 1)'(err);
            e.epoch    = EW'(ep);
            if (err == 0 || ep == MAXE) begin
                e.busy = 1'b0;
                e.done = 1'b1;
                e.conv = (err == 0);
                repeat (3) q.push_back(e);
                break;
            end
        end
    endtask

    // Per-cycle comparison against the model trace
    logic prev_learn = 1'b0;
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = dut_vec();
        if (prev_learn) check("learn_not_back_to_back", 64'(learn), 64'd0);
        prev_learn = learn;
        if (busy) busy_total = busy_total + 1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cycle_trace", 64'(got), 64'(e));
        end
    end

    task automatic wr(input int a, input logic [15:0] p, input logic l);
        @(posedge clk); #1;
        samp_we = 1'b1; samp_addr = AW'(a); samp_pat = p; samp_lbl = l;
        @(posedge clk); #1;
        samp_we = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() > 0 && n < 5000) begin @(posedge clk); n++; end
        check({name, "_trace_timeout"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic run(input string name, input int mode, input bit intrude,
                       input int exp_busy, input int exp_learn, input int exp_epoch,
                       input logic exp_conv, input int exp_last);
        int b0;
        int l0;
        int mbusy;
        @(posedge clk); #1;
        stub_mode  = mode;
        learn_base = learn_total;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b0    = busy_total;
        l0    = learn_total;
        build(mode, mbusy);
        check({name, "_model_busy"}, 64'(mbusy), 64'(exp_busy));
        if (intrude) begin
            repeat (10) @(posedge clk);
            #1;
            samp_we = 1'b1; samp_addr = 3'd2; samp_pat = 16'hFFFF; samp_lbl = 1'b0;
            start   = 1'b1;
            @(posedge clk); #1;
            samp_we = 1'b0; start = 1'b0;
        end
        drain(name);
        check({name, "_busy_cycles"}, 64'(busy_total - b0), 64'(exp_busy));
        check({name, "_learn_pulses"}, 64'(learn_total - l0), 64'(exp_learn));
        check({name, "_epoch_cnt"}, 64'(epoch_cnt), 64'(exp_epoch));
        check({name, "_converged"}, 64'(converged), 64'(exp_conv));
        check({name, "_last_err"}, 64'(last_err_cnt), 64'(exp_last));
        check({name, "_done"}, 64'(done), 64'd1);
        $display("run %s: busy=%0d learn=%0d epoch=%0d conv=%0b last_err=%0d",
                 name, busy_total - b0, learn_total - l0, epoch_cnt, converged, last_err_cnt);
    endtask

    localparam logic [7:0] LBLS = 8'b0100_1101;   // four O, four X

    initial begin
        int n;
        logic [7:0] lbls;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        samp_we = 1'b0; samp_addr = '0; samp_pat = '0; samp_lbl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(dut_vec()), 64'd0);
        rst = 1'b0;

        lbls = LBLS;
        for (int s = 0; s < NUM; s++) begin
            m_lbl[s] = lbls[s];
            m_pat[s] = (lbls[s] ? PAT_O : PAT_X) ^ 16'(s);
            wr(s, m_pat[s], m_lbl[s]);
        end

        run("all_correct",  0, 1'b0, 41,  0,  1, 1'b1, 0);
        run("always_O",     1, 1'b0, 171, 12, 3, 1'b0, 4);
        run("learns_once",  2, 1'b0, 86,  1,  2, 1'b1, 0);

        // abort during SETTLE
        @(posedge clk); #1;
        stub_mode = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!learn && n < 100) begin @(posedge clk); #1; n++; end
        check("abort_saw_learn", 64'(learn), 64'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle_outputs", 64'({busy, done, learn}), 64'd0);
        check("abort_keeps_err", 64'(err_cnt), 64'd1);
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check("abort_beats_start", 64'(busy), 64'd0);
        $display("abort scenario: busy=%0b done=%0b err=%0d", busy, done, err_cnt);

        run("rerun_after_abort", 0, 1'b0, 41, 0, 1, 1'b1, 0);
        run("ignored_we_start",  0, 1'b1, 41, 0, 1, 1'b1, 0);

        // rewrite sample 2 while DONE; the next run must present it
        wr(2, 16'h9669, 1'b0);
        m_pat[2] = 16'h9669;
        m_lbl[2] = 1'b0;
        run("rewritten_idx2", 0, 1'b0, 41, 0, 1, 1'b1, 0);

        // asynchronous reset in the middle of EVAL
        @(posedge clk); #1;
        stub_mode = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_eval", 64'(dut_vec()), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = learn_total;
        repeat (20) @(posedge clk);
        #1;
        check("no_learn_after_reset", 64'(learn_total - n), 64'd0);
        check("idle_after_reset", 64'({busy, done}), 64'd0);
        $display("reset scenario: busy=%0b learn_pulses=%0d", busy, learn_total - n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
